// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg : shared NPC encoding, fetch state encoding, NOP constant
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

  // Same encoding the main decoder drives on npc_op
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_EXEC = 2'd2,
    FETCH_TRAP = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_next_pc_calc.sv
// ============================================================================
// next_pc_calc : combinational next-PC selection from the decoder's NPC op
// Revision: 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic [31:0] next_pc
);

  // Unknown codes fall back to sequential flow
  always_comb begin
    next_pc = pc + 32'd4;
    case (npc_op)
      NPC_BRANCH, NPC_JUMP: next_pc = pc + imm;
      NPC_JALR:             next_pc = alu_out & ~32'h1;
      default:              next_pc = pc + 32'd4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : PC owner and req/ack instruction fetch, one instr in flight
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  input  logic        advance,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        instr_valid,
  output logic        misaligned
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_nxt, instr_nxt, next_pc;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .npc_op  (npc_op),
    .imm     (imm),
    .alu_out (alu_out),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FETCH_IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

  // A misaligned target leaves pc on the faulting instruction
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    case (state)
      FETCH_IDLE: state_nxt = FETCH_REQ;
      FETCH_REQ: begin
        if (im_ack) begin
          instr_nxt = im_rdata;
          state_nxt = FETCH_EXEC;
        end
      end
      FETCH_EXEC: begin
        if (advance) begin
          if (next_pc[1:0] != 2'b00) begin
            state_nxt = FETCH_TRAP;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = FETCH_REQ;
          end
        end
      end
      FETCH_TRAP: state_nxt = FETCH_TRAP;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  assign im_req      = (state == FETCH_REQ);
  assign im_addr     = pc;
  assign instr_valid = (state == FETCH_EXEC);
  assign misaligned  = (state == FETCH_TRAP);
  assign pc_plus4    = pc + 32'd4;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : randomized fetch/retire traffic with a scoreboarded monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  npc_op;
  logic [31:0] imm, alu_out;
  logic        advance;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] pc, pc_plus4, instr;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic        instr_valid, misaligned;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .npc_op(npc_op), .imm(imm), .alu_out(alu_out),
    .advance(advance), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .op(op),
    .funct3(funct3), .funct7(funct7), .instr_valid(instr_valid),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr[$];   // fetch addresses the model expects, in order
  logic [31:0] exp_instr[$];  // words handed out by the memory model
  logic [31:0] model_pc;
  bit          mem_auto;
  int          lat_sel;       // 0: random latency 1..4, else fixed
  int          cur_lat;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Spec-level next-PC rule
  function automatic logic [31:0] ref_next(logic [31:0] p, logic [2:0] o,
                                           logic [31:0] i, logic [31:0] a);
    if (o == 3'b001 || o == 3'b010) return p + i;
    if (o == 3'b100) return {a[31:1], 1'b0};
    return p + 32'd4;
  endfunction

  // Memory model: acks after cur_lat request cycles, junk acks outside requests
  initial begin : responder
    bit req_seen;
    int cnt;
    req_seen = 0; cnt = 0;
    im_ack = 1'b0; im_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_auto) begin
        req_seen = 0;
      end else if (!rstn || !im_req) begin
        req_seen = 0;
        im_ack   = 1'($urandom_range(0, 1));
        im_rdata = $urandom;
      end else begin
        if (!req_seen) begin
          req_seen = 1;
          cur_lat  = (lat_sel == 0) ? int'($urandom_range(1, 4)) : lat_sel;
          cnt      = cur_lat - 1;
        end
        if (cnt == 0) begin
          im_ack   = 1'b1;
          im_rdata = $urandom;
          exp_instr.push_back(im_rdata);
        end else begin
          im_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT starts a fetch and when it presents an instruction
  initial begin : monitor
    bit prev_req, prev_acc;
    int req_len;
    logic [31:0] cur_pc, w;
    prev_req = 0; prev_acc = 0; req_len = 0; cur_pc = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_req = 0; prev_acc = 0; req_len = 0;
      end else begin
        if (prev_acc) begin
          check("req_drop_after_ack", 32'(im_req), 32'd0);
          check("valid_after_ack", 32'(instr_valid), 32'd1);
          check("req_cycles", req_len, cur_lat);
          if (exp_instr.size() == 0) begin
            check("instr_queue_empty", 32'd0, 32'd1);
          end else begin
            w = exp_instr.pop_front();
            check("instr", instr, w);
            check("op", 32'(op), 32'(w[6:0]));
            check("funct3", 32'(funct3), 32'(w[14:12]));
            check("funct7", 32'(funct7), 32'(w[31:25]));
            check("pc", pc, cur_pc);
            check("pc_plus4", pc_plus4, cur_pc + 32'd4);
          end
        end
        if (prev_req && !im_req && !prev_acc)
          check("req_dropped_without_ack", 32'd1, 32'd0);
        if (im_req && !prev_req) begin
          req_len = 1;
          if (exp_addr.size() == 0) begin
            check("unexpected_req", im_addr, 32'hxxxx_xxxx);
          end else begin
            cur_pc = exp_addr.pop_front();
            check("fetch_addr", im_addr, cur_pc);
          end
        end else if (im_req) begin
          req_len++;
          check("addr_stable", im_addr, cur_pc);
        end
        prev_acc = im_req && im_ack;
        prev_req = im_req;
      end
    end
  end

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1;
    end
    if (!seen) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_advance(logic [2:0] o, logic [31:0] i, logic [31:0] a);
    logic [31:0] nxt;
    wait_valid();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, model_pc);
    end
    #1;
    npc_op = o; imm = i; alu_out = a; advance = 1'b1;
    nxt = ref_next(model_pc, o, i, a);
    if (nxt[1:0] == 2'b00) begin
      exp_addr.push_back(nxt);
      model_pc = nxt;
    end
    @(posedge clk); #1;
    advance = 1'b0;
    npc_op  = 3'($urandom);
    imm     = $urandom;
    alu_out = $urandom;
  endtask

  task automatic rand_advance();
    do_advance(3'($urandom), $urandom & ~32'h3, $urandom & ~32'h2);
  endtask

  initial begin : watchdog
    #400000;
    check("watchdog_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    rstn = 1'b0; advance = 1'b0; npc_op = '0; imm = '0; alu_out = '0;
    mem_auto = 1; lat_sel = 1; cur_lat = 1;
    model_pc = RESET_PC;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_req", 32'(im_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);

    // Reset release with immediate acks
    exp_addr.push_back(RESET_PC);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("req_1clk_after_rstn", 32'(im_req), 32'd1);
    check("first_addr", im_addr, RESET_PC);
    @(negedge clk);
    check("valid_after_first_fetch", 32'(instr_valid), 32'd1);

    // Sequential flow, latency 3
    lat_sel = 3;
    do_advance(3'b000, 32'h0, 32'h0);
    do_advance(3'b000, 32'h0, 32'h0);
    lat_sel = 0;

    // Backward branch, then JALR with bit 0 set
    do_advance(3'b100, 32'h0, 32'h0000_0100);
    do_advance(3'b001, 32'hFFFF_FFF8, 32'h0);
    do_advance(3'b100, 32'h0, 32'h0000_0205);

    // Wrap at the top of the address space
    do_advance(3'b100, 32'h0, 32'hFFFF_FFFC);
    do_advance(3'b000, 32'h0, 32'h0);

    repeat (30) rand_advance();

    // Misaligned jump traps and is sticky
    do_advance(3'b100, 32'h0, 32'h0000_0040);
    do_advance(3'b010, 32'h0000_0006, 32'h0);
    repeat (4) begin
      @(negedge clk);
      check("trap_misaligned", 32'(misaligned), 32'd1);
      check("trap_req", 32'(im_req), 32'd0);
      check("trap_valid", 32'(instr_valid), 32'd0);
      check("trap_pc", pc, 32'h0000_0040);
    end
    #1 advance = 1'b1; npc_op = 3'b100; alu_out = 32'h0000_0080;
    repeat (2) @(posedge clk);
    #1 advance = 1'b0;
    @(negedge clk);
    check("trap_ignores_advance", pc, 32'h0000_0040);

    // Reset during a request; a late ack must be discarded
    mem_auto = 0; im_ack = 1'b0;
    #2 rstn = 1'b0;
    @(negedge clk);
    check("rst2_misaligned", 32'(misaligned), 32'd0);
    exp_addr.delete(); exp_instr.delete();
    exp_addr.push_back(RESET_PC);
    model_pc = RESET_PC;
    #2 rstn = 1'b1;
    for (int i = 0; i < 10 && !im_req; i++) @(negedge clk);
    check("rst2_req", 32'(im_req), 32'd1);
    #2 rstn = 1'b0;
    #1 check("req_drops_async", 32'(im_req), 32'd0);
    @(posedge clk); #1;
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("ack_discarded_instr", instr, NOP);
    check("ack_discarded_valid", 32'(instr_valid), 32'd0);
    im_ack = 1'b0;
    exp_addr.push_back(RESET_PC);
    rstn = 1'b1;
    mem_auto = 1;
    wait_valid();
    check("restart_pc", pc, RESET_PC);

    repeat (8) rand_advance();
    wait_valid();
    repeat (2) @(negedge clk);
    check("addr_queue_drained", exp_addr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
